// File: rtl/a_io_l3_in_serialize_a_m_axi_srl_fifo_if.sv
// Valid/ready bundle for the IO_L3 serializer m_axi SRL FIFO.
// Write side (s_*) flows into the FIFO, read side (m_*) flows out.
// The FIFO connects through slave; the producer/consumer side uses master.
interface a_io_l3_in_serialize_a_m_axi_srl_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/a_io_l3_in_serialize_a_m_axi_srl_fifo.sv
// Purpose: shift-register FIFO with registered show-ahead head word, count and flags.
// Latency: write into an empty FIFO is visible on m_data one edge later (bypass).
// Backpressure: s_ready drops at DEPTH words or during flush; m_ready stall holds head.
module a_io_l3_in_serialize_a_m_axi_srl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63,
  parameter int AF_LEVEL   = 60,
  parameter int AE_LEVEL   = 2
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          clk_en,
  input  logic                                          flush,
  a_io_l3_in_serialize_a_m_axi_srl_fifo_if.slave        bus,
  output logic [ADDR_WIDTH:0]                           count,
  output logic                                          almost_full,
  output logic                                          almost_empty
);

  localparam int CW        = ADDR_WIDTH + 1;
  // Keep the array legal when DEPTH == 1; the SRL path is then never used.
  localparam int SRL_DEPTH = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [CW-1:0]         srl_count_q, srl_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] mem_q [SRL_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SRL_DEPTH];

  logic                  s_ready_w;
  logic                  m_valid_w;
  logic                  push;
  logic                  pop;
  logic                  free;
  logic                  bypass;
  logic                  refill;
  logic                  srl_push;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Outputs derive only from registered state, gated by flush.
  assign count        = srl_count_q + CW'(out_valid_q);
  assign s_ready_w    = (count < CW'(DEPTH)) & ~flush;
  assign m_valid_w    = out_valid_q & ~flush;
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign bus.s_ready  = s_ready_w;
  assign bus.m_valid  = m_valid_w;
  assign bus.m_data   = m_data_q;

  // Handshake decode; push already excludes flush through s_ready_w.
  assign push     = clk_en & bus.s_valid & s_ready_w;
  assign pop      = clk_en & m_valid_w & bus.m_ready;
  assign free     = ~out_valid_q | pop;
  assign bypass   = push & free & (srl_count_q == '0);
  assign refill   = free & (srl_count_q != '0);
  assign srl_push = push & ~bypass;
  // Oldest SRL word sits at the top of the occupied region.
  assign rd_idx   = ADDR_WIDTH'(srl_count_q - CW'(1));

  // Next-state for head register and SRL occupancy.
  always_comb begin
    srl_count_d = srl_count_q;
    out_valid_d = out_valid_q;
    m_data_d    = m_data_q;
    if (clk_en) begin
      if (flush) begin
        srl_count_d = '0;
        out_valid_d = 1'b0;
        m_data_d    = '0;
      end else begin
        if (bypass) begin
          m_data_d    = bus.s_data;
          out_valid_d = 1'b1;
        end else if (refill) begin
          m_data_d    = mem_q[rd_idx];
          out_valid_d = 1'b1;
        end else if (free) begin
          out_valid_d = 1'b0;
        end
        srl_count_d = srl_count_q + CW'(srl_push) - CW'(refill);
      end
    end
  end

  // Shift-register next-state: newest word enters at index 0.
  always_comb begin
    mem_d = mem_q;
    if (srl_push && (DEPTH > 1)) begin
      for (int i = 1; i < SRL_DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = bus.s_data;
    end
  end

  // Control and head-word registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srl_count_q <= '0;
      out_valid_q <= 1'b0;
      m_data_q    <= '0;
    end else begin
      srl_count_q <= srl_count_d;
      out_valid_q <= out_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  // SRL storage is deliberately not reset so it maps onto shift-register primitives.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_srl_fifo.sv
// Bench for the m_axi SRL FIFO at DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// A queue model predicts every output each cycle; directed literals pin the model.
module tb_a_io_l3_in_serialize_a_m_axi_srl_fifo;
  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_en;
  logic          flush;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  a_io_l3_in_serialize_a_m_axi_srl_fifo_if #(.DATA_WIDTH(DW)) bus ();

  a_io_l3_in_serialize_a_m_axi_srl_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
    .bus(bus), .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of held words plus the last word shown.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  bit            do_push, do_pop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_last = '0;
    end else if (clk_en) begin
      if (flush) begin
        mq.delete();
        m_last = '0;
      end else begin
        do_push = bus.s_valid && (mq.size() < DEPTH);
        do_pop  = bus.m_ready && (mq.size() > 0);
        if (do_pop) m_last = mq.pop_front();
        if (do_push) mq.push_back(bus.s_data);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en && reset_n) begin
      chk("mdl_count", 32'(count), 32'(mq.size()));
      chk("mdl_s_ready", 32'(bus.s_ready), 32'((mq.size() < DEPTH) && !flush));
      chk("mdl_m_valid", 32'(bus.m_valid), 32'((mq.size() > 0) && !flush));
      chk("mdl_m_data", bus.m_data, (mq.size() > 0) ? mq[0] : m_last);
      chk("mdl_af", 32'(almost_full), 32'(mq.size() >= AF));
      chk("mdl_ae", 32'(almost_empty), 32'(mq.size() <= AE));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    clk_en      = 1'b1;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #22;
    reset_n  = 1'b1;
    check_en = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", bus.m_data, 32'h0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    cyc();

    // Fill to full with the consumer stalled.
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 32'hA1 + 32'(i);
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_head", bus.m_data, 32'hA1);
    end
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    chk("full_af", 32'(almost_full), 32'd1);
    bus.s_data = 32'hA5;
    cyc();
    chk("full_refused", 32'(count), 32'd4);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", bus.m_data, 32'hA1 + 32'(i));
      cyc();
    end
    chk("drain_m_valid", 32'(bus.m_valid), 32'd0);
    chk("drain_hold", bus.m_data, 32'hA4);

    // Single word through the bypass path.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h55;
    cyc();
    chk("byp_m_valid", 32'(bus.m_valid), 32'd1);
    chk("byp_m_data", bus.m_data, 32'h55);
    chk("byp_count", 32'(count), 32'd1);
    bus.s_valid = 1'b0;
    cyc();
    chk("byp_popped", 32'(count), 32'd0);

    // Steady state: two words held, push and pop each cycle.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h10;
    cyc();
    bus.s_data  = 32'h11;
    cyc();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.s_data = 32'h12 + 32'(i);
      chk("stream_head", bus.m_data, 32'h10 + 32'(i));
      cyc();
      chk("stream_count", 32'(count), 32'd2);
    end
    chk("stream_af", 32'(almost_full), 32'd0);
    chk("stream_ae", 32'(almost_empty), 32'd0);

    // Flush with three words held and both sides active.
    bus.m_ready = 1'b0;
    bus.s_data  = 32'h26;
    cyc();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush       = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_data  = 32'h99;
    #1;
    chk("flush_s_ready", 32'(bus.s_ready), 32'd0);
    chk("flush_m_valid", 32'(bus.m_valid), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_m_data", bus.m_data, 32'h0);
    bus.m_ready = 1'b0;
    bus.s_data  = 32'h77;
    cyc();
    chk("post_flush_data", bus.m_data, 32'h77);
    chk("post_flush_vld", 32'(bus.m_valid), 32'd1);

    // Clock enable low freezes everything.
    clk_en      = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_data  = 32'h88;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("frz_count", 32'(count), 32'd1);
      chk("frz_data", bus.m_data, 32'h77);
    end
    clk_en = 1'b1;
    cyc();
    chk("resume_data", bus.m_data, 32'h88);
    chk("resume_count", 32'(count), 32'd1);
    bus.s_valid = 1'b0;
    cyc();
    chk("resume_empty", 32'(count), 32'd0);

    // Reset pulsed between edges while holding three words.
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 32'hB1 + 32'(i);
      cyc();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_m_data", bus.m_data, 32'h0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_stale", 32'(bus.m_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a_io_l3_in_serialize_a_m_axi_srl_fifo.md
# a_io_l3_in_serialize_a_m_axi_srl_fifo

Parametrised shift-register FIFO for the m_axi read/write-data paths of the IO_L3 serializer. It wraps SRL-style storage in a complete valid/ready FIFO: show-ahead registered output, first-word bypass, occupancy count, almost-full/almost-empty flags and a synchronous flush. It replaces the bare SRL-plus-external-pointer arrangement inside the m_axi adapter buffers.

## Interface
- DATA_WIDTH, 32, payload width in bits
- ADDR_WIDTH, 6, SRL read-address width; requires 2^ADDR_WIDTH >= DEPTH-1
- DEPTH, 63, total capacity in words (>= 1); SRL holds DEPTH-1, output register holds 1
- AF_LEVEL, 60, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; requires AE_LEVEL < AF_LEVEL <= DEPTH

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; low freezes all state
- flush  in  1  synchronous clear, qualified by clk_en
- s_valid  in  1  write data valid
- s_ready  out  1  FIFO can accept (not full, not flushing)
- s_data  in  DATA_WIDTH  write data
- m_valid  out  1  m_data holds the oldest word
- m_ready  in  1  consumer accepts m_data
- m_data  out  DATA_WIDTH  registered head-of-FIFO word
- count  out  ADDR_WIDTH+1  words held (0..DEPTH)
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL

## Operation
- State: srl_count (0..DEPTH-1), out_valid, m_data register, SRL array mem[0..DEPTH-2] (mem[0] newest). SRL contents are never reset.
- push = clk_en & s_valid & s_ready; pop = clk_en & m_valid & m_ready.
- s_ready = (count < DEPTH) & !flush; independent of m_ready: a full FIFO refuses a write even in a popping cycle.
- m_valid = out_valid & !flush. count = srl_count + out_valid.
- Output slot free this cycle: free = !out_valid | pop.
- Bypass: push & free & srl_count == 0 -> m_data <= s_data, out_valid <= 1; SRL untouched.
- Push to SRL otherwise: shift mem up one place, mem[0] <= s_data.
- Refill: free & srl_count != 0 -> m_data <= mem[srl_count-1] (pre-shift value), out_valid <= 1.
- free & no bypass & no refill -> out_valid <= 0; m_data holds last value.
- srl_count next = srl_count + (push & !bypass) - refill; simultaneous push and refill leave it unchanged.
- DEPTH == 1: no SRL; only the bypass path exists; s_ready = !out_valid & !flush.
- flush (clk_en high): srl_count <= 0, out_valid <= 0, m_data <= 0; overrides push and pop in the same cycle, and that beat is discarded.
- clk_en low: no state change, handshakes are not counted, and outputs keep reflecting the held state.

## Timing
- Reset (async assert, sync release) gives srl_count=0, out_valid=0, m_data=0, so s_ready=1, m_valid=0, count=0, almost_empty=1, almost_full=0.
- First-word latency: a write into an empty FIFO at edge N gives m_valid=1 with that data after edge N.
- Write latency when the output is occupied: the word enters the SRL and reaches m_data on the refill edge after every older word has popped.
- Sustained throughput is 1 push + 1 pop per cycle at any occupancy 1..DEPTH-1.
- All outputs come from registers, gated only by flush; there is no combinational path from s_valid/m_ready to s_ready/m_valid.
- Flags and count update on the same edge as the handshake that changes occupancy.

## Test plan
- Reset mid-stream with DEPTH=4 holding 3 words, reset_n pulsed low between edges -> immediately count=0, m_valid=0, m_data=0, s_ready=1; no stale word emerges afterwards.
- DEPTH=4, push 0xA1..0xA4 with m_ready=0 -> count 1,2,3,4, s_ready=0 after the 4th, m_data=0xA1 from edge 1; a 5th write while full is refused; then pop 4 -> 0xA1..0xA4 in order, m_valid=0 after.
- Empty FIFO, single push 0x55 at edge N with m_ready=1 -> m_valid=1, m_data=0x55 after N; popped at N+1; count 0->1->0; no SRL write.
- DEPTH=4 holding 2 words, push and pop every cycle for 20 cycles with an incrementing pattern -> count constant at 2 and output order strictly increasing; AF_LEVEL=3 / AE_LEVEL=1 flags stay 0.
- flush asserted with s_valid=1, m_ready=1 and 3 words held -> that cycle s_ready=0, m_valid=0; after the edge count=0 and m_data=0; the next push of 0x77 appears after one edge.
- clk_en=0 for 5 cycles while s_valid=1 and m_ready=1 -> count, m_data and flags unchanged; resumes correctly when clk_en=1.
